// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of a single SDRAM controller port.
// Round-robin on ties, no preemption: a master keeps the bus for as long as
// it holds cyc, and the grant only changes on a clock edge.
module wb_sdram_arbiter #(
  parameter int dw     = 32,
  parameter int APP_AW = 26
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  // master 0
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [APP_AW-1:0] m0_addr_i,
  input  logic [dw-1:0]     m0_dat_i,
  input  logic [dw/8-1:0]   m0_sel_i,
  input  logic [2:0]        m0_cti_i,
  output logic              m0_ack_o,
  output logic [dw-1:0]     m0_dat_o,
  // master 1
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [APP_AW-1:0] m1_addr_i,
  input  logic [dw-1:0]     m1_dat_i,
  input  logic [dw/8-1:0]   m1_sel_i,
  input  logic [2:0]        m1_cti_i,
  output logic              m1_ack_o,
  output logic [dw-1:0]     m1_dat_o,
  // memory controller side
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [APP_AW-1:0] s_addr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [dw/8-1:0]   s_sel_o,
  output logic [2:0]        s_cti_o,
  input  logic              s_ack_i,
  input  logic [dw-1:0]     s_dat_i,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_last_owner;
  logic       w_last_owner_next;
  logic [1:0] r_gnt;
  logic [1:0] w_gnt_next;

  // State, round-robin pointer and registered grant; last_owner=1 after reset
  // so master 0 wins the first tie.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: non-blocking assignments keep every register in this block
    // updating from the same pre-edge values, independent of statement order.
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_gnt        <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_gnt        <= w_gnt_next;
    end
  end

  // Next-state logic: grant on request, hold while cyc, hand over on release.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    unique case (r_state)
      IDLE: begin
        if (sdr_init_done) begin
          if (m0_cyc_i && m1_cyc_i) w_state_next = r_last_owner ? OWN0 : OWN1;
          else if (m0_cyc_i)        w_state_next = OWN0;
          else if (m1_cyc_i)        w_state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_last_owner_next = 1'b0;
          w_state_next      = (m1_cyc_i && sdr_init_done) ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_last_owner_next = 1'b1;
          w_state_next      = (m0_cyc_i && sdr_init_done) ? OWN0 : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    unique case (w_state_next)
      OWN0:    w_gnt_next = 2'b01;
      OWN1:    w_gnt_next = 2'b10;
      default: w_gnt_next = 2'b00;
    endcase
  end

  assign gnt_o = r_gnt;

  // Bus steering: the owner sees the slave, everyone else sees zeros.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = 3'b000;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    unique case (r_state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: directed scenarios followed by
// random traffic, all compared against an ownership model and a memory model.
module tb_wb_sdram_arbiter;

  localparam int DW = 32;
  localparam int AW = 26;

  logic          clk;
  logic          rst;
  logic          init;
  logic [1:0]    cyc, stb, we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] dat  [2];
  logic [3:0]    sel  [2];
  logic [2:0]    cti  [2];
  logic          s_ack;
  logic [DW-1:0] s_dat;

  logic          m0_ack_o, m1_ack_o;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_dat_o;
  logic [3:0]    s_sel_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    gnt_o;

  wb_sdram_arbiter #(.dw(DW), .APP_AW(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done(init),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_cti_i(cti[0]),
    .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_cti_i(cti[1]),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), who released it last,
  // and the contents of memory as seen through completed write beats.
  int            mdl_owner;
  int            mdl_last;
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = 1;
  endtask

  // Applied on every rising edge with the inputs the DUT just sampled.
  task automatic model_edge();
    int other;
    if (rst) begin
      model_reset();
    end else if (mdl_owner < 0) begin
      if (init) begin
        if (cyc[0] && cyc[1]) mdl_owner = 1 - mdl_last;
        else if (cyc[0])      mdl_owner = 0;
        else if (cyc[1])      mdl_owner = 1;
      end
    end else if (!cyc[mdl_owner]) begin
      other    = 1 - mdl_owner;
      mdl_last = mdl_owner;
      mdl_owner = (cyc[other] && init) ? other : -1;
    end
  endtask

  // Half-cycle: drive slave read data, then compare every output.
  task automatic tick_check();
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dat;
    logic [3:0]    e_sel;
    logic [2:0]    e_cti;
    logic [1:0]    e_gnt;
    logic [1:0]    e_ack;
    logic [DW-1:0] e_mdat [2];
    int            o;
    @(negedge clk);
    o = mdl_owner;
    if (o >= 0 && !we[o] && mem.exists(addr[o])) s_dat = mem[addr[o]];
    else                                          s_dat = $urandom;
    #1;
    e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_dat = '0; e_sel = '0; e_cti = '0;
    e_ack = 2'b00; e_mdat[0] = '0; e_mdat[1] = '0;
    e_gnt = (o < 0) ? 2'b00 : (o == 0 ? 2'b01 : 2'b10);
    if (o >= 0) begin
      e_cyc = cyc[o]; e_stb = stb[o]; e_we = we[o]; e_addr = addr[o];
      e_dat = dat[o]; e_sel = sel[o]; e_cti = cti[o];
      e_ack[o] = s_ack; e_mdat[o] = s_dat;
    end
    check("gnt",    gnt_o,    e_gnt);
    check("s_cyc",  s_cyc_o,  e_cyc);
    check("s_stb",  s_stb_o,  e_stb);
    check("s_we",   s_we_o,   e_we);
    check("s_addr", s_addr_o, e_addr);
    check("s_dat",  s_dat_o,  e_dat);
    check("s_sel",  s_sel_o,  e_sel);
    check("s_cti",  s_cti_o,  e_cti);
    check("m0_ack", m0_ack_o, e_ack[0]);
    check("m1_ack", m1_ack_o, e_ack[1]);
    check("m0_dat", m0_dat_o, e_mdat[0]);
    check("m1_dat", m1_dat_o, e_mdat[1]);
    if (o >= 0 && cyc[o] && stb[o] && we[o] && s_ack) mem[addr[o]] = dat[o];
  endtask

  task automatic tick_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    tick_check();
    tick_edge();
  endtask

  int acks1, acks0;

  initial begin
    rst = 1'b1; init = 1'b0; cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_dat = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; dat[i] = '0; sel[i] = '0; cti[i] = '0;
    end
    @(posedge clk); #1;
    model_reset();

    // Reset state
    tick_check();
    check("rst_gnt", gnt_o, 2'b00);
    tick_edge();
    rst = 1'b0;

    // Grant withheld until controller is initialised
    init = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 26'h40; dat[0] = 32'h1234;
    sel[0] = 4'hF;
    repeat (20) tick();
    init = 1'b1;
    tick();
    tick_check();
    check("init_gnt", gnt_o, 2'b01);
    tick_edge();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (2) tick();

    // Tie after reset goes to m0, then back-to-back handover to m1
    rst = 1'b1; tick(); rst = 1'b0;
    cyc = 2'b11; stb = 2'b11;
    tick();
    tick_check();
    check("tie_m0", gnt_o, 2'b01);
    tick_edge();
    cyc[0] = 1'b0;
    tick();
    tick_check();
    check("handoff_m1", gnt_o, 2'b10);
    tick_edge();

    // m1 incrementing burst while m0 keeps requesting
    cyc[0] = 1'b1; stb[0] = 1'b1; acks0 = 0; acks1 = 0;
    for (int b = 0; b < 8; b++) begin
      cti[1] = (b == 7) ? 3'b111 : 3'b010; stb[1] = 1'b1; we[1] = 1'b0;
      addr[1] = 26'h200 + 26'(b); s_ack = 1'b1;
      tick_check();
      if (m1_ack_o) acks1++;
      if (m0_ack_o) acks0++;
      tick_edge();
    end
    check("burst_m1_acks", 64'(acks1), 64'd8);
    check("burst_m0_acks", 64'(acks0), 64'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
    tick();
    tick_check();
    check("m0_after_burst", gnt_o, 2'b01);
    tick_edge();

    // m0 writes, m1 reads the same word back
    we[0] = 1'b1; addr[0] = 26'h0000100; dat[0] = 32'hA5A5A5A5; sel[0] = 4'hF;
    cti[0] = 3'b111; s_ack = 1'b1;
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; s_ack = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 26'h0000100; cti[1] = 3'b000;
    tick();
    s_ack = 1'b1;
    tick_check();
    check("rd_ack",  m1_ack_o, 1'b1);
    check("rd_data", m1_dat_o, 32'hA5A5A5A5);
    tick_edge();

    // Reset in the middle of an m1 burst
    cti[1] = 3'b010;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cyc = 2'b11; stb = 2'b11;
    tick_check();
    check("midrst_gnt",  gnt_o,   2'b00);
    check("midrst_scyc", s_cyc_o, 1'b0);
    tick_edge();
    tick_check();
    check("midrst_tie_m0", gnt_o, 2'b01);
    tick_edge();

    // Spurious ack while idle
    cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
    tick();
    s_ack = 1'b1;
    repeat (3) begin
      tick_check();
      check("idle_m0_ack", m0_ack_o, 1'b0);
      check("idle_m1_ack", m1_ack_o, 1'b0);
      tick_edge();
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      init = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) cyc[i] = ~cyc[i];
        stb[i]  = $urandom_range(0, 1);
        we[i]   = $urandom_range(0, 1);
        addr[i] = 26'($urandom_range(0, 15));
        dat[i]  = $urandom;
        sel[i]  = 4'($urandom);
        cti[i]  = 3'($urandom);
      end
      s_ack = $urandom_range(0, 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
